// File: rtl/seq_muldiv_pkg.sv
// Shared types and op-class predicates for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_MULH  = 3'd1,
    OP_MULHU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_REM   = 3'd5,
    OP_REMU  = 3'd6,
    OP_RSVD  = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_high(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/seq_muldiv_if.sv
// Start/busy/done request bus between the execute stage and the multiply/divide unit.
interface seq_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (output start, op, a, b, input busy, done, result, div_by_zero);
  modport slave  (input start, op, a, b, output busy, done, result, div_by_zero);
endinterface

// File: rtl/seq_muldiv_step.sv
// One iteration of the datapath: shift-add for multiply, restoring trial subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               div_mode,
  output logic [2*WIDTH:0]   acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   diff;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    trial    = {acc[2*WIDTH:WIDTH], acc[WIDTH-1]};
    diff     = trial[WIDTH:0] - {1'b0, operand};
    acc_next = {1'b0, sum, acc[WIDTH-1:1]};
    // divide: remainder in acc[2W:W], dividend shifts out of the top of acc[W-1:0] as quotient bits enter
    if (div_mode) begin
      if (trial >= {2'b00, operand})
        acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {trial[WIDTH:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_muldiv.sv
// Iterative M-extension multiply/divide, one bit per cycle, fixed WIDTH+2 latency.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one multiply/divide iteration per cycle, counter counts down to 0
//   FIX   | sign fixup and result half select
//   DONE  | done pulse; a start here is accepted like IDLE
module seq_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  seq_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  muldiv_state_t    state;
  muldiv_op_t       op_r;
  logic [CW-1:0]    cnt;
  logic             neg_a, neg_b, dbz_pend;
  logic [WIDTH-1:0] operand;
  logic [2*WIDTH:0] acc, acc_next;
  logic             busy_r, done_r, dbz_r;
  logic [WIDTH-1:0] result_r;

  muldiv_op_t       op_in;
  logic             accept, neg_a_in, neg_b_in;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    op_in    = muldiv_op_t'(bus.op);
    accept   = bus.start && ((state == S_IDLE) || (state == S_DONE));
    neg_a_in = is_signed(op_in) && bus.a[WIDTH-1];
    neg_b_in = is_signed(op_in) && bus.b[WIDTH-1];
    mag_a    = neg_a_in ? -bus.a : bus.a;
    mag_b    = neg_b_in ? -bus.b : bus.b;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand),
    .div_mode (is_div(op_r)),
    .acc_next (acc_next)
  );

  logic [2*WIDTH-1:0] prod, prod_neg, prod_fix;
  logic [WIDTH-1:0]   quo, quo_neg, rem, rem_neg, fix_result;

  // With b == 0 the restoring loop leaves quotient = all ones and remainder = |a|,
  // so the dividend-sign fixup on the remainder returns a unchanged.
  always_comb begin
    prod       = acc[2*WIDTH-1:0];
    prod_neg   = -prod;
    prod_fix   = (neg_a ^ neg_b) ? prod_neg : prod;
    quo        = acc[WIDTH-1:0];
    quo_neg    = -quo;
    rem        = acc[2*WIDTH-1:WIDTH];
    rem_neg    = -rem;
    fix_result = '0;
    case (op_r)
      OP_MUL, OP_MULH, OP_MULHU:
        fix_result = is_high(op_r) ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
      OP_DIV:  fix_result = dbz_pend ? '1 : ((neg_a ^ neg_b) ? quo_neg : quo);
      OP_DIVU: fix_result = dbz_pend ? '1 : quo;
      OP_REM:  fix_result = neg_a ? rem_neg : rem;
      OP_REMU: fix_result = rem;
      default: fix_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_r     <= OP_MUL;
      cnt      <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      dbz_pend <= 1'b0;
      operand  <= '0;
      acc      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
      result_r <= '0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        state    <= S_RUN;
        op_r     <= op_in;
        cnt      <= CNT_LOAD;
        neg_a    <= neg_a_in;
        neg_b    <= neg_b_in;
        dbz_pend <= is_div(op_in) && (bus.b == '0);
        operand  <= is_div(op_in) ? mag_b : mag_a;
        acc      <= {(WIDTH + 1)'(0), is_div(op_in) ? mag_a : mag_b};
        busy_r   <= 1'b1;
        dbz_r    <= 1'b0;
      end else begin
        case (state)
          S_RUN: begin
            acc <= acc_next;
            if (cnt == '0) state <= S_FIX;
            else           cnt   <= cnt - 1'b1;
          end
          S_FIX: begin
            result_r <= fix_result;
            dbz_r    <= dbz_pend;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state    <= S_DONE;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.result      = result_r;
  assign bus.div_by_zero = dbz_r;

endmodule
